// File: rtl/alu_input_sequencer.sv
// alu_input_sequencer
//   Front-end for the 2-bit logic unit. A single bouncy push-button steps
//   through three loads: operand A, then operand B, then opcode I. Each load
//   takes the value on the switch bank. After the opcode load the FSM enters
//   SHOW. One cycle later, once the logic unit has settled on the new I, its
//   output F is captured into a held result register.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   sw[1:0]      operand/opcode switches, sampled on accepted presses
//   btn          raw asynchronous push-button, high = pressed
//   alu_f[1:0]   combinational F from the logic unit
//   A[1:0]       registered operand A to the logic unit
//   B[1:0]       registered operand B to the logic unit
//   I[1:0]       registered opcode to the logic unit
//   result[1:0]  captured F
//   result_valid high while result holds F for the current A/B/I
//   state_led    current FSM state encoding

module alu_input_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw,
  input  logic       btn,
  input  logic [1:0] alu_f,
  output logic [1:0] A,
  output logic [1:0] B,
  output logic [1:0] I,
  output logic [1:0] result,
  output logic       result_valid,
  output logic [1:0] state_led
);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    LOAD_I = 2'b10,
    SHOW   = 2'b11
  } state_t;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic             db, db_q;
  logic [CNT_W-1:0] cnt;
  logic             press;
  logic             cap_pend;
  state_t           state;

  // Synchronizer and debouncer. The counter only advances while the
  // synchronized level disagrees with the accepted level, so any excursion
  // shorter than DEBOUNCE_CYCLES edges is forgotten as soon as it ends.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, as real flops do.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      db_q <= db;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Rising edge of the debounced level: one cycle per accepted press.
  assign press = db & ~db_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOAD_A;
      A            <= 2'b00;
      B            <= 2'b00;
      I            <= 2'b00;
      result       <= 2'b00;
      result_valid <= 1'b0;
      cap_pend     <= 1'b0;
    end else begin
      case (state)
        LOAD_A: if (press) begin
          A     <= sw;
          state <= LOAD_B;
        end
        LOAD_B: if (press) begin
          B     <= sw;
          state <= LOAD_I;
        end
        LOAD_I: if (press) begin
          I        <= sw;
          cap_pend <= 1'b1;
          state    <= SHOW;
        end
        SHOW: begin
          // I became visible to the logic unit at the edge that entered
          // SHOW, so alu_f is already valid for the new opcode here. A
          // press cannot coincide with this cycle because presses are
          // separated by at least two debounce windows.
          if (cap_pend) begin
            result       <= alu_f;
            result_valid <= 1'b1;
            cap_pend     <= 1'b0;
          end else if (press) begin
            result_valid <= 1'b0;
            state        <= LOAD_A;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  assign state_led = state;

endmodule

// File: tb/tb_alu_input_sequencer.sv
module tb_alu_input_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sw;
  logic       btn;
  logic [1:0] alu_f;
  logic [1:0] a, b, op, result, state_led;
  logic       result_valid;

  int checks   = 0;
  int failures = 0;

  alu_input_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .btn          (btn),
    .alu_f        (alu_f),
    .A            (a),
    .B            (b),
    .I            (op),
    .result       (result),
    .result_valid (result_valid),
    .state_led    (state_led)
  );

  always #5 clk = ~clk;

  // Model of the downstream 2-bit logic unit.
  always_comb begin
    alu_f = 2'b00;
    case (op)
      2'b00: alu_f = a & b;
      2'b01: alu_f = a | b;
      2'b10: alu_f = ~(a ^ b);
      2'b11: alu_f = ~a;
      default: alu_f = 2'b00;
    endcase
  end

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    btn = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Clean press: 10 cycles high, 10 cycles low (both exceed sync + debounce).
  task automatic do_press(input logic [1:0] v);
    btn = 1'b1;
    sw  = v;
    repeat (10) tick();
    btn = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 1'b1;
    sw  = 2'b11;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({a, b, op, result, result_valid, state_led} !== 13'b0) begin
        failures++;
        $display("FAIL reset_cycle%0d: A=%b B=%b I=%b result=%b valid=%b state=%b expected all zero",
                 k, a, b, op, result, result_valid, state_led);
      end
    end
    rst = 1'b0;
    btn = 1'b0;
    repeat (10) tick();
    checks++;
    if (state_led !== 2'b00 || a !== 2'b00) begin
      failures++;
      $display("FAIL reset_no_load: state=%b A=%b expected 00/00", state_led, a);
    end
  endtask

  task automatic test_full_sequence();
    apply_reset();
    do_press(2'b10);
    checks++;
    if (a !== 2'b10 || state_led !== 2'b01) begin
      failures++;
      $display("FAIL seq_load_a: A=%b state=%b expected 10/01", a, state_led);
    end
    do_press(2'b11);
    checks++;
    if (b !== 2'b11 || state_led !== 2'b10) begin
      failures++;
      $display("FAIL seq_load_b: B=%b state=%b expected 11/10", b, state_led);
    end
    btn = 1'b1;
    sw  = 2'b01;
    repeat (6) tick();
    checks++;
    if (state_led !== 2'b10) begin
      failures++;
      $display("FAIL seq_edge6: state=%b expected 10", state_led);
    end
    tick();  // edge 7
    checks++;
    if (state_led !== 2'b11 || op !== 2'b01 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL seq_edge7: state=%b I=%b valid=%b expected 11/01/0", state_led, op, result_valid);
    end
    tick();  // edge 8: 10 | 11 = 11
    checks++;
    if (result !== 2'b11 || result_valid !== 1'b1) begin
      failures++;
      $display("FAIL seq_edge8: result=%b valid=%b expected 11/1", result, result_valid);
    end
    repeat (2) tick();
    btn = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_return_from_show();
    btn = 1'b1;
    sw  = 2'b00;
    repeat (6) tick();
    checks++;
    if (result_valid !== 1'b1 || state_led !== 2'b11) begin
      failures++;
      $display("FAIL ret_edge6: valid=%b state=%b expected 1/11", result_valid, state_led);
    end
    tick();  // edge 7
    checks++;
    if (result_valid !== 1'b0 || state_led !== 2'b00 || result !== 2'b11 ||
        a !== 2'b10 || b !== 2'b11 || op !== 2'b01) begin
      failures++;
      $display("FAIL ret_edge7: valid=%b state=%b result=%b A=%b B=%b I=%b expected 0/00/11/10/11/01",
               result_valid, state_led, result, a, b, op);
    end
    repeat (3) tick();
    btn = 1'b0;
    repeat (10) tick();
    do_press(2'b01);
    do_press(2'b10);
    do_press(2'b11);  // NOT A with A=01 -> 10
    checks++;
    if (result !== 2'b10 || result_valid !== 1'b1 || state_led !== 2'b11) begin
      failures++;
      $display("FAIL ret_not_a: result=%b valid=%b state=%b expected 10/1/11", result, result_valid, state_led);
    end
  endtask

  task automatic test_bounce();
    apply_reset();
    sw = 2'b11;
    btn = 1'b1; repeat (3) tick();
    btn = 1'b0; repeat (2) tick();
    btn = 1'b1; repeat (3) tick();
    btn = 1'b0; repeat (12) tick();
    checks++;
    if (state_led !== 2'b00 || a !== 2'b00) begin
      failures++;
      $display("FAIL bounce_reject: state=%b A=%b expected 00/00", state_led, a);
    end
    do_press(2'b11);
    checks++;
    if (state_led !== 2'b01 || a !== 2'b11) begin
      failures++;
      $display("FAIL bounce_clean: state=%b A=%b expected 01/11", state_led, a);
    end
  endtask

  task automatic test_held_button();
    int bad;
    bad = 0;
    apply_reset();
    btn = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      sw = 2'((k * 3) % 4);  // edge 7 sees 01
      tick();
      if (k == 6) begin
        checks++;
        if (state_led !== 2'b00) begin
          failures++;
          $display("FAIL held_edge6: state=%b expected 00", state_led);
        end
      end
      if (k >= 7 && (state_led !== 2'b01 || a !== 2'b01)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL held_single_load: %0d cycles off, last state=%b A=%b expected 01/01", bad, state_led, a);
    end
    btn = 1'b0;
    repeat (10) tick();
    checks++;
    if (state_led !== 2'b01 || a !== 2'b01) begin
      failures++;
      $display("FAIL held_release: state=%b A=%b expected 01/01", state_led, a);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    do_press(2'b11);
    do_press(2'b01);
    checks++;
    if (state_led !== 2'b10 || a !== 2'b11 || b !== 2'b01) begin
      failures++;
      $display("FAIL mid_setup: state=%b A=%b B=%b expected 10/11/01", state_led, a, b);
    end
    btn = 1'b1;
    sw  = 2'b10;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({a, b, op, result, result_valid, state_led} !== 13'b0) begin
      failures++;
      $display("FAIL mid_reset: A=%b B=%b I=%b result=%b valid=%b state=%b expected all zero",
               a, b, op, result, result_valid, state_led);
    end
    repeat (7) tick();
    checks++;
    if (state_led !== 2'b01 || a !== 2'b10 || b !== 2'b00) begin
      failures++;
      $display("FAIL mid_reload_a: state=%b A=%b B=%b expected 01/10/00", state_led, a, b);
    end
    btn = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    sw  = 2'b00;
    test_reset();
    test_full_sequence();
    test_return_from_show();
    test_bounce();
    test_held_button();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_input_sequencer.md
# alu_input_sequencer

Front-end sequencer for the 2-bit logic unit (opcode 00 AND, 01 OR, 10 XNOR, 11 NOT A). It turns a single bouncy push-button and a 2-bit switch bank into the registered operands A, B and opcode I, loaded on three successive presses. On the third press it captures the logic unit's combinational result F into a held result register for display. It sits directly upstream of the logic unit, driving A/B/I, and also consumes the unit's F output.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive clock edges a changed button level must persist before it is accepted; legal range is 1 and up.
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sw  in  2  operand/opcode switches, sampled on accepted presses.
- btn  in  1  raw asynchronous push-button, high = pressed.
- alu_f  in  2  combinational F from the logic unit.
- A  out  2  registered operand A to the logic unit.
- B  out  2  registered operand B to the logic unit.
- I  out  2  registered opcode to the logic unit.
- result  out  2  captured F.
- result_valid  out  1  high while result holds F for the current A/B/I.
- state_led  out  2  current FSM state encoding.

## Operation
- **Synchronizer.** btn passes through a 2-flop synchronizer (s1, s2) before any use.
- **Debouncer.**
  - db is the debounced level; cnt is the debounce counter.
  - When s2 equals db, cnt clears to 0.
  - When s2 differs from db and cnt equals DEBOUNCE_CYCLES-1, db toggles and cnt clears.
  - Otherwise, while s2 differs from db, cnt increments.
  - cnt is $clog2(DEBOUNCE_CYCLES+1) bits wide and never wraps.
- **Press pulse.** press = db & ~db_q, where db_q is db delayed by one flop. It is exactly one cycle long per accepted press; holding the button produces no further pulses.
- **FSM states** (state_led encoding):
  - LOAD_A = 00: on press, A <= sw and go to LOAD_B.
  - LOAD_B = 01: on press, B <= sw and go to LOAD_I.
  - LOAD_I = 10: on press, I <= sw and go to SHOW; set cap_pend.
  - SHOW = 11:
    - On the first SHOW cycle with cap_pend set: result <= alu_f, result_valid <= 1, clear cap_pend. The logic unit has settled on the new I by then.
    - On press: result_valid <= 0 and go to LOAD_A. result keeps its value.
- **Register hold.** A, B and I hold their values until they are overwritten in their own load state. The logic unit therefore always sees stable registered inputs.
- **Capture timing.** A press in SHOW on the same cycle as a pending capture is impossible, because presses are at least 2·DEBOUNCE_CYCLES apart.
- **Reset values.**
  - state LOAD_A, so state_led = 00.
  - A, B, I, result = 00; result_valid = 0; cap_pend = 0.
  - s1, s2, db, db_q = 0; cnt = 0.
- **Reset mid-operation** (any state, button held or not): all registers take their reset values at that edge. A button still held after reset is accepted as a new press once the debounce completes.

## Timing
- Reference point: btn is stable high before edge 0.
- s2 goes high after edge 2.
- db goes high after edge DEBOUNCE_CYCLES+2.
- press is high during the following cycle.
- The FSM state change and operand load occur at edge DEBOUNCE_CYCLES+3.
- From LOAD_I:
  - SHOW is entered at edge D+3.
  - result and result_valid update at edge D+4, so they are valid 1 cycle after entering SHOW.
- **Release.** Also needs DEBOUNCE_CYCLES stable-low edges and produces no pulse.
- **Glitches.** A glitch on s2 shorter than DEBOUNCE_CYCLES consecutive edges never changes db and clears cnt on return.
- **Latency budget.** No combinational path from btn or sw to any output. alu_f → result is a single register stage.

## Test plan
- **Reset.** rst high 2 cycles with btn=1 and sw=11 → A, B, I, result = 00, result_valid = 0, state_led = 00 throughout; no load occurs during reset.
- **Full sequence.** DEBOUNCE_CYCLES=4; bench models the logic unit. Press with sw=10, then 11, then 01 → A=10, B=11, I=01. The third press enters SHOW at edge 7 of that press; result=11 and result_valid=1 at edge 8.
- **Bounce rejection.** DEBOUNCE_CYCLES=4; btn pulses high 3 cycles, low 2, high 3 → no press, state_led stays 00, A unchanged. A clean 10-cycle hold → exactly one press.
- **Held button.** DEBOUNCE_CYCLES=4; btn held 200 cycles in LOAD_A with sw toggling → a single load of A (sw value at edge 7), and state_led = 01 for the rest of the hold.
- **Return from SHOW.** Press in SHOW → result_valid=0 and state_led=00 at edge 7; result and A/B/I retained. A new sequence with opcode 11 and A=01 → result=10.
- **Mid-operation reset.** Reset asserted in LOAD_I with A=11, B=01 → all outputs return to reset values on that edge; the next press loads A.
